fifo_rd_stream: RTL and testbench

//  Downstream drain stage for the synchronous FIFO read port. Issues read_req

---
 rtl/fifo_rd_stream.sv | 69 ++++++
 tb/tb_fifo_rd_stream.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a request/valid FIFO read port into a 2-entry buffer and a valid/ready stream with packet framing.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_LEN    = 16,
  parameter int CNT_W      = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  fifo_empty_i,
  output logic                  read_req_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  input  logic                  rdata_valid_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic [1:0]            occupancy_o,
  output logic                  err_unexp_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PKT_LEN - 1);
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [1:0] count_q, count_d;
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic inflight_q, drop_q, drop_d, err_q, err_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic pop, push;
  logic [2:0] credit;
  assign m_valid_o   = count_q != 2'd0;
  assign m_data_o    = mem_q[rd_ptr_q];
  assign m_last_o    = m_valid_o & (beat_q == LAST);
  assign occupancy_o = count_q;
  assign err_unexp_o = err_q;
  // A request is allowed only if the word it returns is guaranteed a free slot.
  always_comb begin
    pop        = m_valid_o & m_ready_i;
    push       = rdata_valid_i & inflight_q & !drop_q;
    credit     = 3'(count_q) + 3'(inflight_q);
    read_req_o = !fifo_empty_i & !flush_i & !reset_i & (credit < 3'd2 + 3'(pop));
    count_d    = flush_i ? 2'd0 : count_q + 2'(push) - 2'(pop);
    wr_ptr_d   = flush_i ? 1'b0 : wr_ptr_q ^ push;
    rd_ptr_d   = flush_i ? 1'b0 : rd_ptr_q ^ pop;
    beat_d     = flush_i ? '0 : !pop ? beat_q : (beat_q == LAST) ? '0 : beat_q + 1'b1;
    drop_d     = flush_i & inflight_q;
    err_d      = err_q | (rdata_valid_i & !inflight_q & !drop_q);
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      err_q      <= 1'b0;
      beat_q     <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= read_req_o;
      drop_q     <= drop_d;
      err_q      <= err_d;
      beat_q     <= beat_d;
      if (push && !flush_i) mem_q[wr_ptr_q] <= read_data_i;
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: randomized bench with a FIFO model and a word/beat scoreboard for fifo_rd_stream.
module tb_fifo_rd_stream;
  localparam int DW = 16, PL = 16;
  logic clk = 1'b0;
  logic reset = 1'b1, flush = 1'b0, m_ready = 1'b0;
  logic fifo_empty, read_req, rdata_valid, m_valid, m_last, err_unexp;
  logic [DW-1:0] read_data, m_data;
  logic [1:0] occupancy;
  logic [DW-1:0] mem [0:255];
  int wr_idx = 0, rd_idx = 0;
  logic fv = 1'b0, inj = 1'b0;
  logic [DW-1:0] fd = '0, inj_d = '0;
  logic [DW-1:0] exp_q [$];
  int beat = 0, errs = 0, checks = 0;

  always #5 clk = ~clk;

  // FIFO model: a request pops the head and returns it one cycle later
  assign fifo_empty  = (wr_idx == rd_idx);
  assign rdata_valid = fv | inj;
  assign read_data   = inj ? inj_d : fd;
  always @(posedge clk) begin
    fv <= read_req;
    if (read_req) begin
      fd     <= mem[rd_idx];
      rd_idx <= rd_idx + 1;
    end
  end

  fifo_rd_stream #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_W(8)) dut (
    .clk_i(clk), .reset_i(reset), .flush_i(flush), .fifo_empty_i(fifo_empty),
    .read_req_o(read_req), .read_data_i(read_data), .rdata_valid_i(rdata_valid),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
    .occupancy_o(occupancy), .err_unexp_o(err_unexp));

  task automatic load(input int n, input bit rnd, input int base);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w;
      w = rnd ? DW'($urandom) : DW'(base + i);
      mem[wr_idx] = w;
      exp_q.push_back(w);
      wr_idx++;
    end
  endtask

  task automatic test_reset();
    load(1, 1'b0, 16'hA5A5);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if (read_req !== 1'b0) begin errs++; $display("FAIL reset_read_req: got %b expected 0", read_req); end
      checks++; if (m_valid !== 1'b0) begin errs++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
      checks++; if (occupancy !== 2'd0) begin errs++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
      checks++; if (err_unexp !== 1'b0) begin errs++; $display("FAIL reset_err: got %b expected 0", err_unexp); end
    end
    checks++; if (m_data !== '0 || m_last !== 1'b0) begin errs++; $display("FAIL reset_data_last: got %h/%b expected 0/0", m_data, m_last); end
  endtask

  task automatic test_single();
    @(negedge clk); reset = 1'b0; m_ready = 1'b1; #1;
    checks++; if (read_req !== 1'b1 || m_valid !== 1'b0) begin errs++; $display("FAIL single_t0: got req=%b valid=%b expected 1/0", read_req, m_valid); end
    @(negedge clk); #1;
    checks++; if (read_req !== 1'b0 || m_valid !== 1'b0) begin errs++; $display("FAIL single_t1: got req=%b valid=%b expected 0/0", read_req, m_valid); end
    @(negedge clk); #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 16'hA5A5) begin errs++; $display("FAIL single_t2: got valid=%b data=%h expected 1/a5a5", m_valid, m_data); end
    checks++; if (occupancy !== 2'd1 || m_last !== 1'b0) begin errs++; $display("FAIL single_occ: got occ=%0d last=%b expected 1/0", occupancy, m_last); end
    void'(exp_q.pop_front());
    @(negedge clk); #1;
    checks++; if (m_valid !== 1'b0 || occupancy !== 2'd0) begin errs++; $display("FAIL single_t3: got valid=%b occ=%0d expected 0/0", m_valid, occupancy); end
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0; beat = 0; #1;
    checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin errs++; $display("FAIL idle_flush: got valid=%b last=%b expected 0/0", m_valid, m_last); end
  endtask

  task automatic test_throughput();
    int nb = 0, nreq = 0, nlast = 0, fr = -1, lr = -1, fb = -1, lb = -1;
    @(negedge clk); m_ready = 1'b1; load(32, 1'b0, 0);
    for (int cyc = 0; cyc < 70; cyc++) begin
      #1;
      if (read_req) begin nreq++; if (fr < 0) fr = cyc; lr = cyc; end
      if (m_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errs++; $display("FAIL tput_extra: got %h expected no beat", m_data); end
        else if (m_data !== exp_q[0] || m_last !== (beat == PL - 1)) begin errs++; $display("FAIL tput_beat%0d: got %h/%b expected %h/%b", nb, m_data, m_last, exp_q[0], beat == PL - 1); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (m_last) nlast++;
        beat = (beat + 1) % PL; nb++;
        if (fb < 0) fb = cyc; lb = cyc;
      end
      if (nb == 32) break;
      @(negedge clk);
    end
    checks++; if (nb != 32 || lb - fb != 31) begin errs++; $display("FAIL tput_beats: got %0d beats span %0d expected 32 span 31", nb, lb - fb); end
    checks++; if (nreq != 32 || lr - fr != 31) begin errs++; $display("FAIL tput_reqs: got %0d reqs span %0d expected 32 span 31", nreq, lr - fr); end
    checks++; if (fb - fr != 2) begin errs++; $display("FAIL tput_latency: got %0d expected 2", fb - fr); end
    checks++; if (nlast != 2) begin errs++; $display("FAIL tput_lasts: got %0d expected 2", nlast); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] held = '0;
    bit seen = 0;
    @(negedge clk); m_ready = 1'b0; load(8, 1'b1, 0);
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (m_valid && !seen) begin held = m_data; seen = 1; end
      else if (m_valid) begin
        checks++; if (m_data !== held) begin errs++; $display("FAIL bp_stable: got %h expected %h", m_data, held); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (occupancy !== 2'd2 || read_req !== 1'b0) begin errs++; $display("FAIL bp_full: got occ=%0d req=%b expected 2/0", occupancy, read_req); end
    checks++; if (m_data !== exp_q[0]) begin errs++; $display("FAIL bp_head: got %h expected %h", m_data, exp_q[0]); end
    for (int cyc = 0; cyc < 200 && exp_q.size() != 0; cyc++) begin
      @(negedge clk); m_ready = 1'($urandom_range(0, 1)); #1;
      if (m_valid && m_ready) begin
        checks++; if (m_data !== exp_q[0] || m_last !== (beat == PL - 1)) begin errs++; $display("FAIL bp_beat: got %h/%b expected %h/%b", m_data, m_last, exp_q[0], beat == PL - 1); end
        void'(exp_q.pop_front()); beat = (beat + 1) % PL;
      end
    end
    checks++; if (exp_q.size() != 0) begin errs++; $display("FAIL bp_drain: got %0d left expected 0", exp_q.size()); end
    @(negedge clk); m_ready = 1'b1; #1;
    checks++; if (m_valid !== 1'b0 || occupancy !== 2'd0) begin errs++; $display("FAIL bp_empty: got valid=%b occ=%0d expected 0/0", m_valid, occupancy); end
  endtask

  task automatic test_flush();
    int n = 0, nlast = 0;
    @(negedge clk); m_ready = 1'b1; load(40, 1'b0, 100);
    for (int cyc = 0; cyc < 50 && n < 6; cyc++) begin
      #1;
      if (m_valid) begin
        checks++; if (m_data !== exp_q[0]) begin errs++; $display("FAIL flush_pre: got %h expected %h", m_data, exp_q[0]); end
        void'(exp_q.pop_front()); beat = (beat + 1) % PL; n++;
      end
      if (n < 6) @(negedge clk);
    end
    @(negedge clk); flush = 1'b1; #1;
    checks++; if (read_req !== 1'b0) begin errs++; $display("FAIL flush_req: got %b expected 0", read_req); end
    // everything already fetched from the FIFO is gone; framing restarts
    exp_q.delete();
    for (int i = rd_idx; i < wr_idx; i++) exp_q.push_back(mem[i]);
    beat = 0;
    @(negedge clk); flush = 1'b0; #1;
    checks++; if (m_valid !== 1'b0 || occupancy !== 2'd0) begin errs++; $display("FAIL flush_clear: got valid=%b occ=%0d expected 0/0", m_valid, occupancy); end
    n = 0;
    for (int cyc = 0; cyc < 200 && exp_q.size() != 0; cyc++) begin
      m_ready = 1'($urandom_range(0, 3) != 0); #1;
      if (m_valid && m_ready) begin
        checks++; if (m_data !== exp_q[0] || m_last !== (beat == PL - 1)) begin errs++; $display("FAIL flush_post%0d: got %h/%b expected %h/%b", n, m_data, m_last, exp_q[0], beat == PL - 1); end
        if (m_last && nlast == 0) begin
          checks++; if (n != PL - 1) begin errs++; $display("FAIL flush_frame: got first last at beat %0d expected %0d", n, PL - 1); end
          nlast++;
        end
        void'(exp_q.pop_front()); beat = (beat + 1) % PL; n++;
      end
      @(negedge clk);
    end
    #1;
    checks++; if (exp_q.size() != 0 || err_unexp !== 1'b0) begin errs++; $display("FAIL flush_drain: got left=%0d err=%b expected 0/0", exp_q.size(), err_unexp); end
  endtask

  task automatic test_err();
    @(negedge clk); m_ready = 1'b1; #1;
    checks++; if (err_unexp !== 1'b0) begin errs++; $display("FAIL err_quiet: got %b expected 0", err_unexp); end
    @(negedge clk); inj = 1'b1; inj_d = 16'hDEAD;
    @(negedge clk); inj = 1'b0; #1;
    checks++; if (err_unexp !== 1'b1) begin errs++; $display("FAIL err_set: got %b expected 1", err_unexp); end
    checks++; if (occupancy !== 2'd0 || m_valid !== 1'b0) begin errs++; $display("FAIL err_occ: got occ=%0d valid=%b expected 0/0", occupancy, m_valid); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (err_unexp !== 1'b1) begin errs++; $display("FAIL err_sticky: got %b expected 1", err_unexp); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (err_unexp !== 1'b0 || occupancy !== 2'd0) begin errs++; $display("FAIL err_reset: got err=%b occ=%0d expected 0/0", err_unexp, occupancy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_throughput();
    test_backpressure();
    test_flush();
    test_err();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
